// File: rtl/counter_timer_ctrl.sv
// Programmable timer: a prescaled up-counter sequenced by an IDLE/RUN/DONE controller,
// with a valid/ready configuration port, a one-cycle expiry tick and a sticky interrupt.
module counter_timer_ctrl #(
  parameter int COUNTER_WIDTH  = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [COUNTER_WIDTH-1:0]  cfg_period,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  input  logic                      cfg_periodic,
  input  logic                      start,
  input  logic                      stop,
  output logic [COUNTER_WIDTH-1:0]  cnt,
  output logic                      tick,
  output logic                      busy,
  output logic                      done,
  output logic                      irq,
  input  logic                      irq_clear
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                    state_q;
  logic [COUNTER_WIDTH-1:0]  cnt_q;
  logic [COUNTER_WIDTH-1:0]  period_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] psc_q;
  logic                      periodic_q;
  logic                      tick_q;
  logic                      irq_q;

  logic cfg_fire;
  logic step;
  logic expire;

  // A stop on the same edge suppresses the step, so an aborted run never ticks.
  assign cfg_fire = cfg_valid && (state_q != S_RUN);
  assign step     = (state_q == S_RUN) && !stop && (psc_q == prescale_q);
  assign expire   = step && (cnt_q == period_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      period_q   <= '1;
      prescale_q <= '0;
      psc_q      <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      tick_q <= expire;

      if (cfg_fire) begin
        period_q   <= cfg_period;
        prescale_q <= cfg_prescale;
        periodic_q <= cfg_periodic;
      end

      unique case (state_q)
        S_RUN: begin
          if (stop) begin
            state_q <= S_IDLE;
          end else if (step) begin
            psc_q <= '0;
            if (!expire) begin
              cnt_q <= cnt_q + 1'b1;
            end else if (periodic_q) begin
              cnt_q <= '0;
            end else begin
              state_q <= S_DONE;
            end
          end else begin
            psc_q <= psc_q + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE: a start launches with whatever config is latched on this edge.
          if (stop) begin
            state_q <= S_IDLE;
          end else if (start) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            psc_q   <= '0;
          end
        end
      endcase

      if (expire) begin
        irq_q <= 1'b1;
      end else if (irq_clear) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign cnt       = cnt_q;
  assign tick      = tick_q;
  assign irq       = irq_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign cfg_ready = (state_q != S_RUN);

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Bench for counter_timer_ctrl: directed scenarios with literal expectations plus random
// stimulus, all checked every cycle against an elapsed-time arithmetic model of the timer.
module tb_counter_timer_ctrl;

  localparam int CW = 32;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_period;
  logic [PW-1:0] cfg_prescale;
  logic          cfg_periodic;
  logic          start;
  logic          stop;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          busy;
  logic          done;
  logic          irq;
  logic          irq_clear;

  counter_timer_ctrl #(.COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_prescale(cfg_prescale), .cfg_periodic(cfg_periodic),
    .start(start), .stop(stop), .cnt(cnt), .tick(tick), .busy(busy), .done(done),
    .irq(irq), .irq_clear(irq_clear)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: while running, everything follows from r = cycles elapsed since the run began.
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  int              m_mode;
  longint unsigned m_r, m_cnt, m_period, m_pre, m_len;
  bit              m_per, m_tick, m_irq, m_exp, m_was_run;

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      m_mode = M_IDLE; m_cnt = 0; m_tick = 0; m_irq = 0; m_r = 0;
      m_period = (64'd1 << CW) - 1; m_pre = 0; m_per = 0;
    end else begin
      m_exp = 0;
      m_was_run = (m_mode == M_RUN);
      if (cfg_valid && !m_was_run) begin
        m_period = cfg_period; m_pre = cfg_prescale; m_per = cfg_periodic;
      end
      if (m_was_run) begin
        if (stop) m_mode = M_IDLE;
        else begin
          m_r++;
          m_len = (m_period + 1) * (m_pre + 1);
          if (m_per) begin
            m_exp = (m_r % m_len == 0);
            m_cnt = (m_r / (m_pre + 1)) % (m_period + 1);
          end else if (m_r == m_len) begin
            m_exp = 1; m_mode = M_DONE; m_cnt = m_period;
          end else begin
            m_cnt = m_r / (m_pre + 1);
          end
        end
      end else if (stop) begin
        m_mode = M_IDLE;
      end else if (start) begin
        m_mode = M_RUN; m_r = 0; m_cnt = 0;
      end
      m_tick = m_exp;
      if (m_exp) m_irq = 1;
      else if (irq_clear) m_irq = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (cnt !== m_cnt[CW-1:0] || tick !== m_tick || irq !== m_irq ||
          busy !== (m_mode == M_RUN) || done !== (m_mode == M_DONE) ||
          cfg_ready !== (m_mode != M_RUN)) begin
        miscompares++;
        $display("FAIL model t=%0t: got cnt=%0d tick=%b irq=%b busy=%b done=%b rdy=%b, required cnt=%0d tick=%b irq=%b busy=%b done=%b rdy=%b",
                 $time, cnt, tick, irq, busy, done, cfg_ready, m_cnt[CW-1:0], m_tick, m_irq,
                 m_mode == M_RUN, m_mode == M_DONE, m_mode != M_RUN);
      end
    end
  end

  task automatic lit(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; irq_clear = 1'b0;
  endtask

  task automatic configure(input int unsigned per, input int unsigned pre, input bit periodic);
    cfg_valid = 1'b1; cfg_period = per; cfg_prescale = PW'(pre); cfg_periodic = periodic;
  endtask

  // Cycles until a tick is seen, counting the launching edge; saturates at lim.
  task automatic wait_tick(input int lim, output int n);
    n = 0;
    do begin
      step_clk();
      n++;
    end while (!tick && n < lim);
  endtask

  int exp_cnt[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
  int n, last, ticks;

  initial begin
    clear_inputs();
    rst = 1'b0; cfg_period = '0; cfg_prescale = '0; cfg_periodic = 1'b0;
    step_clk(); step_clk();
    rst = 1'b1;
    chk_en = 1'b1;
    lit("reset_cnt", cnt, 0); lit("reset_tick", tick, 0); lit("reset_busy", busy, 0);
    lit("reset_done", done, 0); lit("reset_irq", irq, 0); lit("reset_ready", cfg_ready, 1);

    // Periodic basic
    configure(3, 0, 1); step_clk(); cfg_valid = 1'b0;
    start = 1'b1; step_clk(); start = 1'b0;
    lit("per_busy", busy, 1);
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) step_clk();
      lit("per_cnt", cnt, exp_cnt[c-1]);
      lit("per_tick", tick, (c == 5 || c == 9) ? 1 : 0);
    end
    lit("per_irq", irq, 1);
    stop = 1'b1; step_clk(); stop = 1'b0;

    // Prescale: ticks 6 apart, each one cycle wide
    configure(1, 2, 1); step_clk(); cfg_valid = 1'b0;
    start = 1'b1; step_clk(); start = 1'b0;
    last = -1;
    for (int c = 1; c <= 40; c++) begin
      step_clk();
      if (tick) begin
        if (last >= 0) lit("presc_gap", c - last, 6);
        last = c;
      end
    end
    lit("presc_seen", (last >= 0), 1);
    stop = 1'b1; step_clk(); stop = 1'b0;

    // One-shot
    configure(2, 0, 0); step_clk(); cfg_valid = 1'b0;
    start = 1'b1; wait_tick(20, n); start = 1'b0;
    lit("oneshot_tick_at", n, 4);
    lit("oneshot_done", done, 1); lit("oneshot_busy", busy, 0); lit("oneshot_cnt", cnt, 2);
    ticks = 0;
    for (int c = 0; c < 20; c++) begin step_clk(); ticks += tick; end
    lit("oneshot_no_more_ticks", ticks, 0);
    lit("oneshot_cnt_held", cnt, 2);
    start = 1'b1; step_clk(); start = 1'b0;
    lit("restart_busy", busy, 1); lit("restart_cnt", cnt, 0); lit("restart_done", done, 0);
    stop = 1'b1; step_clk(); stop = 1'b0;

    // Config offered during RUN is ignored
    configure(3, 0, 1); step_clk(); cfg_valid = 1'b0;
    start = 1'b1; step_clk(); start = 1'b0;
    configure(100, 0, 1);
    lit("run_cfg_ready", cfg_ready, 0);
    wait_tick(50, n);
    lit("run_cfg_ignored_tick_at", n + 1, 5);
    cfg_valid = 1'b0;
    stop = 1'b1; step_clk(); stop = 1'b0;

    // start+stop together in IDLE
    start = 1'b1; stop = 1'b1; step_clk(); start = 1'b0; stop = 1'b0;
    lit("startstop_busy", busy, 0); lit("startstop_done", done, 0);

    // irq_clear on the expiry edge
    irq_clear = 1'b1; step_clk(); irq_clear = 1'b0;
    lit("irq_cleared", irq, 0);
    start = 1'b1; step_clk(); start = 1'b0;
    for (int c = 2; c <= 4; c++) step_clk();
    lit("pre_expiry_irq", irq, 0); lit("pre_expiry_cnt", cnt, 3);
    irq_clear = 1'b1; step_clk(); irq_clear = 1'b0;
    lit("collide_tick", tick, 1); lit("collide_irq", irq, 1);
    stop = 1'b1; step_clk(); stop = 1'b0;

    // Config and start on the same edge
    configure(5, 0, 1); start = 1'b1; wait_tick(50, n); cfg_valid = 1'b0; start = 1'b0;
    lit("cfgstart_tick_at", n, 7);

    // Reset mid-run with cnt=7 and irq=1
    stop = 1'b1; step_clk(); stop = 1'b0;
    configure(9, 0, 1); step_clk(); cfg_valid = 1'b0;
    start = 1'b1; step_clk(); start = 1'b0;
    n = 0;
    while (!(m_cnt == 7 && m_irq) && n < 40) begin step_clk(); n++; end
    lit("midrst_cnt", cnt, 7); lit("midrst_irq", irq, 1);
    rst = 1'b0; step_clk(); rst = 1'b1;
    lit("midrst_cnt0", cnt, 0); lit("midrst_tick0", tick, 0); lit("midrst_busy0", busy, 0);
    lit("midrst_done0", done, 0); lit("midrst_irq0", irq, 0); lit("midrst_ready", cfg_ready, 1);
    start = 1'b1; step_clk(); start = 1'b0;
    ticks = 0;
    for (int c = 0; c < 100; c++) begin step_clk(); ticks += tick; end
    lit("default_period_no_tick", ticks, 0);
    lit("default_period_cnt", cnt, 100);
    stop = 1'b1; step_clk(); stop = 1'b0;

    // Stop mid-run
    configure(10, 0, 1); step_clk(); cfg_valid = 1'b0;
    start = 1'b1; step_clk(); start = 1'b0;
    for (int c = 0; c < 4; c++) step_clk();
    lit("stop_cnt_before", cnt, 4);
    stop = 1'b1; step_clk(); stop = 1'b0;
    lit("stop_busy", busy, 0); lit("stop_cnt_held", cnt, 4);
    lit("stop_tick", tick, 0); lit("stop_ready", cfg_ready, 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 199) != 0);
      cfg_valid    = ($urandom_range(0, 3) == 0);
      cfg_period   = CW'($urandom_range(0, 6));
      cfg_prescale = PW'($urandom_range(0, 3));
      cfg_periodic = 1'($urandom_range(0, 1));
      start        = ($urandom_range(0, 7) == 0);
      stop         = ($urandom_range(0, 29) == 0);
      irq_clear    = ($urandom_range(0, 9) == 0);
      step_clk();
    end
    clear_inputs();
    step_clk();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_timer_ctrl.md
Name: counter_timer_ctrl

Overview:
Controller that sequences a prescaled up-counter as a programmable timer. It accepts a period/prescale configuration through a valid/ready handshake and runs one-shot or periodic on start/stop commands. It emits a one-cycle tick on each expiry and keeps a sticky interrupt flag. It sits between a register/control front-end and any logic needing timed events.

Parameters:
COUNTER_WIDTH, 32, width of main count and period
PRESCALE_WIDTH, 8, width of prescale divider value

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration can be accepted (state IDLE or DONE)
cfg_period  input  COUNTER_WIDTH  terminal count value
cfg_prescale  input  PRESCALE_WIDTH  count advances every cfg_prescale+1 cycles
cfg_periodic  input  1  1 = auto-reload, 0 = one-shot
start  input  1  launch timer
stop  input  1  abort timer
cnt  output  COUNTER_WIDTH  current count
tick  output  1  one-cycle pulse on expiry
busy  output  1  state RUN
done  output  1  state DONE (one-shot finished)
irq  output  1  sticky expiry flag
irq_clear  input  1  clears irq

Behaviour:
- Reset (rst=0 at edge): state IDLE; cnt=0, tick=0, busy=0, done=0, irq=0; internal period=all-ones, prescale=0, periodic=0, prescale counter=0. Reset overrides everything, including mid-run and mid-handshake.
- States: IDLE, RUN, DONE. busy = (state==RUN), done = (state==DONE), cfg_ready = (state!=RUN). All are registered/state-decoded with no combinational path from inputs.
- Config: a transfer happens on an edge with cfg_valid & cfg_ready. period, prescale and periodic are latched. cnt is not changed. cfg_valid in RUN is ignored; the requester holds it until cfg_ready.
- Config and start on the same edge: the new config is latched and the start uses the new values.
- IDLE/DONE + start (stop=0) -> RUN next cycle, with cnt=0, prescale counter=0 and done=0.
- start while in RUN: ignored.
- stop in RUN -> IDLE next cycle. cnt holds its last value. tick is not generated.
- stop and start on the same edge: stop wins (RUN->IDLE, IDLE/DONE stays or goes to IDLE). stop in DONE -> IDLE.
- RUN, each cycle:
  - If prescale counter == prescale: prescale counter <= 0 and a step occurs.
  - Otherwise: prescale counter increments.
- Step:
  - If cnt != period: cnt <= cnt+1.
  - If cnt == period (expiry): tick=1 for exactly the next cycle and irq <= 1.
    - Periodic: cnt <= 0 and stays in RUN.
    - One-shot: cnt holds at period and goes to DONE.
- Timing: expiry period = (period+1)*(prescale+1) cycles. period=0 gives a tick every prescale+1 cycles. cnt never exceeds period and never wraps through 2^COUNTER_WIDTH.
- irq: set by expiry, cleared by irq_clear. Expiry and clear on the same edge: set wins.
- tick is 0 in all cycles except the one following an expiry step. It is never asserted in IDLE/DONE except as the single pulse on the DONE entry cycle.

Test Plan:
- Periodic basic: reset; config period=3, prescale=0, periodic=1; start at cycle 0 -> busy=1 from cycle 1; cnt = 0,1,2,3 on cycles 1-4; cnt=0 with tick=1 on cycle 5; next tick on cycle 9; irq=1 from cycle 5.
- Prescale: period=1, prescale=2, periodic=1 -> cnt changes every 3 cycles; ticks exactly 6 cycles apart; tick width always 1 cycle.
- One-shot: period=2, prescale=0, periodic=0; start -> tick once; state DONE with done=1, busy=0, cnt=2 held; 20 further cycles with no tick. A second start -> RUN with cnt=0, done=0.
- Handshake/collisions:
  - cfg_valid during RUN -> cfg_ready=0 and period unchanged.
  - start+stop on the same edge in IDLE -> stays IDLE.
  - irq_clear on the expiry edge -> irq=1.
  - Config+start on the same edge with period=5 -> first tick after 6 steps.
- Reset mid-operation: rst=0 for one edge while RUN with cnt=7 and irq=1 -> next cycle all outputs 0, state IDLE. A following start with no new config uses period=all-ones (no tick within 100 cycles).
- Stop mid-run: period=10; stop at cnt=4 -> IDLE; cnt stays 4; no tick; cfg_ready=1 next cycle.
